// File: rtl/screen_sequencer.sv
// screen_sequencer: system-level screen FSM and frame-buffer write mux.
// Runs the title, game and you-win subsystems in turn. It holds a level RUN_* command to the
// active subsystem and advances on that subsystem's *_DONE pulse. Every screen change goes
// through a full-screen BG_COLOR clear.
// Ports:
//   CLOCK_50, RESET_H           clock, synchronous active-high reset
//   START, WIN_FLAG             player start pulse, game outcome
//   RUN_TITLE/GAME/YOU_WIN      level run commands (registered state decodes)
//   *_DONE                      completion pulses from the subsystems
//   *_WE, *_DOUT, *_X, *_Y      subsystem write ports
//   FB_WE, FB_DOUT, FB_X, FB_Y  registered frame-buffer write port
//   BUSY_CLEAR                  high while the background clear runs
module screen_sequencer #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_H,
  input  logic       START,
  input  logic       WIN_FLAG,
  output logic       RUN_TITLE,
  output logic       RUN_GAME,
  output logic       RUN_YOU_WIN,
  input  logic       TITLE_DONE,
  input  logic       GAME_DONE,
  input  logic       YOU_WIN_DONE,
  input  logic       TITLE_WE,
  input  logic       GAME_WE,
  input  logic       YOU_WIN_WE,
  input  logic [7:0] TITLE_DOUT,
  input  logic [7:0] GAME_DOUT,
  input  logic [7:0] YOU_WIN_DOUT,
  input  logic [8:0] TITLE_X,
  input  logic [8:0] TITLE_Y,
  input  logic [8:0] GAME_X,
  input  logic [8:0] GAME_Y,
  input  logic [8:0] YOU_WIN_X,
  input  logic [8:0] YOU_WIN_Y,
  output logic       FB_WE,
  output logic [7:0] FB_DOUT,
  output logic [8:0] FB_X,
  output logic [8:0] FB_Y,
  output logic       BUSY_CLEAR
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [8:0] XLast = 9'(WIDTH - 1);
  localparam logic [8:0] YLast = 9'(HEIGHT - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StClear, StTitle, StWaitStart, StGame, StYouWin, StHold} state_e;
  typedef enum logic [1:0] {RetTitle, RetGame, RetYouWin} ret_e;

  state_e           state_q, state_d;
  ret_e             ret_q, ret_d;
  logic [8:0]       cx_q, cx_d, cy_q, cy_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             fb_we_q, fb_we_d;
  logic [7:0]       fb_dout_q, fb_dout_d;
  logic [8:0]       fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic             run_title_q, run_game_q, run_you_win_q;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    hold_d    = hold_q;
    fb_we_d   = 1'b0;
    fb_dout_d = fb_dout_q;
    fb_x_d    = fb_x_q;
    fb_y_d    = fb_y_q;
    case (state_q)
      StClear: begin
        fb_we_d   = 1'b1;
        fb_dout_d = BG_COLOR;
        fb_x_d    = cx_q;
        fb_y_d    = cy_q;
        if (cx_q == XLast) begin
          cx_d = '0;
          if (cy_q == YLast) begin
            cy_d = '0;
            case (ret_q)
              RetGame:   state_d = StGame;
              RetYouWin: state_d = StYouWin;
              default:   state_d = StTitle;
            endcase
          end else begin
            cy_d = cy_q + 9'd1;
          end
        end else begin
          cx_d = cx_q + 9'd1;
        end
      end
      StTitle: begin
        fb_we_d = TITLE_WE;
        if (TITLE_WE) begin
          fb_dout_d = TITLE_DOUT;
          fb_x_d    = TITLE_X;
          fb_y_d    = TITLE_Y;
        end
        if (TITLE_DONE) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (START) begin
          ret_d   = RetGame;
          state_d = StClear;
        end
      end
      StGame: begin
        fb_we_d = GAME_WE;
        if (GAME_WE) begin
          fb_dout_d = GAME_DOUT;
          fb_x_d    = GAME_X;
          fb_y_d    = GAME_Y;
        end
        if (GAME_DONE) begin
          ret_d   = WIN_FLAG ? RetYouWin : RetTitle;
          state_d = StClear;
        end
      end
      StYouWin: begin
        fb_we_d = YOU_WIN_WE;
        if (YOU_WIN_WE) begin
          fb_dout_d = YOU_WIN_DOUT;
          fb_x_d    = YOU_WIN_X;
          fb_y_d    = YOU_WIN_Y;
        end
        if (YOU_WIN_DONE) state_d = StHold;
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          ret_d   = RetTitle;
          state_d = StClear;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      state_q       <= StClear;
      ret_q         <= RetTitle;
      cx_q          <= '0;
      cy_q          <= '0;
      hold_q        <= '0;
      fb_we_q       <= 1'b0;
      fb_dout_q     <= '0;
      fb_x_q        <= '0;
      fb_y_q        <= '0;
      run_title_q   <= 1'b0;
      run_game_q    <= 1'b0;
      run_you_win_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      hold_q        <= hold_d;
      fb_we_q       <= fb_we_d;
      fb_dout_q     <= fb_dout_d;
      fb_x_q        <= fb_x_d;
      fb_y_q        <= fb_y_d;
      // Decoded from the current state, so RUN_* trail state entry/exit by one cycle.
      run_title_q   <= (state_q == StTitle);
      run_game_q    <= (state_q == StGame);
      run_you_win_q <= (state_q == StYouWin);
    end
  end

  assign RUN_TITLE   = run_title_q;
  assign RUN_GAME    = run_game_q;
  assign RUN_YOU_WIN = run_you_win_q;
  assign FB_WE       = fb_we_q;
  assign FB_DOUT     = fb_dout_q;
  assign FB_X        = fb_x_q;
  assign FB_Y        = fb_y_q;
  assign BUSY_CLEAR  = (state_q == StClear);

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed screen flow with randomized pixel data and spurious pulses.
// A screen-level reference model predicts every registered output.
module tb_screen_sequencer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int HC = 5;
  localparam logic [7:0] BG = 8'h3C;

  localparam int MClear = 0;
  localparam int MTitle = 1;
  localparam int MWait  = 2;
  localparam int MGame  = 3;
  localparam int MWin   = 4;
  localparam int MHold  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, win_flag = 1'b0;
  logic       run_title, run_game, run_you_win;
  logic       title_done = 1'b0, game_done = 1'b0, you_win_done = 1'b0;
  logic       title_we = 1'b0, game_we = 1'b0, you_win_we = 1'b0;
  logic [7:0] title_dout = '0, game_dout = '0, you_win_dout = '0;
  logic [8:0] title_x = '0, title_y = '0, game_x = '0, game_y = '0;
  logic [8:0] you_win_x = '0, you_win_y = '0;
  logic       fb_we;
  logic [7:0] fb_dout;
  logic [8:0] fb_x, fb_y;
  logic       busy_clear;

  int total = 0;
  int bad = 0;
  int obs_writes = 0;

  // Reference model: screen name, return screen, linear clear index, hold count.
  int m_mode = MClear;
  int m_ret = MTitle;
  int m_k = 0;
  int m_hold = 0;

  screen_sequencer #(
    .WIDTH(W), .HEIGHT(H), .BG_COLOR(BG), .HOLD_CYCLES(HC)
  ) dut (
    .CLOCK_50(clk), .RESET_H(rst), .START(start), .WIN_FLAG(win_flag),
    .RUN_TITLE(run_title), .RUN_GAME(run_game), .RUN_YOU_WIN(run_you_win),
    .TITLE_DONE(title_done), .GAME_DONE(game_done), .YOU_WIN_DONE(you_win_done),
    .TITLE_WE(title_we), .GAME_WE(game_we), .YOU_WIN_WE(you_win_we),
    .TITLE_DOUT(title_dout), .GAME_DOUT(game_dout), .YOU_WIN_DOUT(you_win_dout),
    .TITLE_X(title_x), .TITLE_Y(title_y), .GAME_X(game_x), .GAME_Y(game_y),
    .YOU_WIN_X(you_win_x), .YOU_WIN_Y(you_win_y),
    .FB_WE(fb_we), .FB_DOUT(fb_dout), .FB_X(fb_x), .FB_Y(fb_y), .BUSY_CLEAR(busy_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: predict from current inputs, advance the model, clock, compare.
  task automatic tick();
    logic       e_we = 1'b0;
    logic [7:0] e_dout = '0;
    logic [8:0] e_x = '0, e_y = '0;
    logic       e_rt, e_rg, e_ry;
    bit         was_rst = rst;
    e_rt = !rst && m_mode == MTitle;
    e_rg = !rst && m_mode == MGame;
    e_ry = !rst && m_mode == MWin;
    if (rst) begin
      m_mode = MClear; m_ret = MTitle; m_k = 0; m_hold = 0;
    end else begin
      case (m_mode)
        MClear: begin
          e_we = 1'b1; e_dout = BG; e_x = 9'(m_k % W); e_y = 9'(m_k / W);
          m_k++;
          if (m_k == W * H) begin m_k = 0; m_mode = m_ret; end
        end
        MTitle: begin
          e_we = title_we; e_dout = title_dout; e_x = title_x; e_y = title_y;
          if (title_done) m_mode = MWait;
        end
        MWait: if (start) begin m_ret = MGame; m_mode = MClear; end
        MGame: begin
          e_we = game_we; e_dout = game_dout; e_x = game_x; e_y = game_y;
          if (game_done) begin m_ret = win_flag ? MWin : MTitle; m_mode = MClear; end
        end
        MWin: begin
          e_we = you_win_we; e_dout = you_win_dout; e_x = you_win_x; e_y = you_win_y;
          if (you_win_done) m_mode = MHold;
        end
        default: begin
          if (m_hold == HC - 1) begin m_hold = 0; m_ret = MTitle; m_mode = MClear; end
          else m_hold++;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (fb_we === 1'b1) obs_writes++;
    check("fb_we", 32'(fb_we), 32'(e_we));
    if (was_rst || e_we) begin
      check("fb_dout", 32'(fb_dout), 32'(e_dout));
      check("fb_x", 32'(fb_x), 32'(e_x));
      check("fb_y", 32'(fb_y), 32'(e_y));
    end
    check("run_title", 32'(run_title), 32'(e_rt));
    check("run_game", 32'(run_game), 32'(e_rg));
    check("run_you_win", 32'(run_you_win), 32'(e_ry));
    check("busy_clear", 32'(busy_clear), 32'(m_mode == MClear));
  endtask

  // Random pixel traffic; pulses only where the current screen must ignore them.
  task automatic rand_inputs();
    title_we = 1'($urandom); game_we = 1'($urandom); you_win_we = 1'($urandom);
    title_dout = 8'($urandom); game_dout = 8'($urandom); you_win_dout = 8'($urandom);
    title_x = 9'($urandom); title_y = 9'($urandom);
    game_x = 9'($urandom); game_y = 9'($urandom);
    you_win_x = 9'($urandom); you_win_y = 9'($urandom);
    win_flag = 1'($urandom);
    title_done   = (m_mode != MTitle) && ($urandom_range(0, 3) == 0);
    game_done    = (m_mode != MGame) && ($urandom_range(0, 3) == 0);
    you_win_done = (m_mode != MWin) && ($urandom_range(0, 3) == 0);
    start        = (m_mode != MWait) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic tick_rand(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      tick();
    end
  endtask

  task automatic run_until(input int target, input int bound);
    for (int i = 0; i < bound && m_mode != target; i++) tick_rand(1);
    if (m_mode != target) begin
      total++;
      bad++;
      $error("FAIL run_until: observed mode=%0d expected mode=%0d", m_mode, target);
    end
  endtask

  initial begin
    int n;
    // Reset and the power-on clear.
    rand_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    obs_writes = 0;
    run_until(MTitle, 40);
    check("init_clear_writes", 32'(obs_writes), 32'd8);
    tick_rand(2);

    // Title write routed; identical game write ignored.
    rand_inputs();
    title_we = 1'b1; title_dout = 8'hA5; title_x = 9'd10; title_y = 9'd20;
    game_we = 1'b1; game_dout = 8'hA5; game_x = 9'd10; game_y = 9'd20;
    tick();
    check("title_dout_a5", 32'(fb_dout), 32'h0A5);
    tick_rand(3);

    // START during TITLE is ignored.
    rand_inputs(); start = 1'b1; tick();
    rand_inputs(); title_done = 1'b1; tick();
    tick_rand(3);
    rand_inputs(); start = 1'b1; tick();
    run_until(MGame, 40);
    tick_rand(4);

    // Spurious YOU_WIN_DONE in GAME, then a win.
    rand_inputs(); you_win_done = 1'b1; tick();
    rand_inputs(); game_done = 1'b1; win_flag = 1'b1; tick();
    rand_inputs(); game_done = 1'b1; win_flag = 1'b0; tick();
    run_until(MWin, 40);
    tick_rand(3);
    rand_inputs(); you_win_done = 1'b1; you_win_we = 1'b1; tick();
    n = 0;
    while (n < 20) begin
      tick_rand(1);
      if (fb_we === 1'b1) break;
      n++;
    end
    check("hold_idle_cycles", 32'(n), 32'd5);
    run_until(MTitle, 40);

    // Loss returns to title.
    rand_inputs(); title_done = 1'b1; tick();
    rand_inputs(); start = 1'b1; tick();
    run_until(MGame, 40);
    tick_rand(2);
    rand_inputs(); game_done = 1'b1; win_flag = 1'b0; game_we = 1'b1; tick();
    run_until(MTitle, 40);
    tick_rand(2);

    // Reset mid-game with a pending write.
    rand_inputs(); title_done = 1'b1; tick();
    rand_inputs(); start = 1'b1; tick();
    run_until(MGame, 40);
    tick_rand(3);
    rand_inputs(); game_we = 1'b1; rst = 1'b1; tick();
    rst = 1'b0;
    obs_writes = 0;
    run_until(MTitle, 40);
    check("reset_clear_writes", 32'(obs_writes), 32'd8);
    tick_rand(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
